// File: rtl/bp_be_fe_cmd_arbiter.sv
// Arbitrates the BE->FE command channel across redirect sources into a small FIFO.
// Optional per-requester grant counters are enabled by defining BP_BE_FE_CMD_ARB_STATS_EN.
module bp_be_fe_cmd_arbiter #(
    parameter int                   num_req_p     = 4,
    parameter int                   cmd_width_p   = 64,
    parameter int                   fifo_els_p    = 2,
    parameter logic [num_req_p-1:0] serial_mask_p = 4'b1000
) (
    input  logic                             clk_i,
    input  logic                             reset_i,
    input  logic                             freeze_i,
    input  logic                             flush_i,
    input  logic [num_req_p-1:0]             req_v_i,
    input  logic [num_req_p*cmd_width_p-1:0] req_cmd_i,
    output logic [num_req_p-1:0]             req_yumi_o,
    output logic [cmd_width_p-1:0]           fe_cmd_o,
    output logic                             fe_cmd_v_o,
    input  logic                             fe_cmd_ready_i,
    output logic                             busy_o,
    output logic [num_req_p*16-1:0]          grant_cnt_o
);

    localparam int rr_w  = (num_req_p > 2) ? $clog2(num_req_p) : 1;
    localparam int fp_w  = (fifo_els_p > 1) ? $clog2(fifo_els_p) : 1;
    localparam int cnt_w = $clog2(fifo_els_p + 1);

    typedef enum logic {e_run, e_drain} state_e;

    state_e                 state_r, state_n;
    logic [rr_w-1:0]        rr_r;
    logic [fp_w-1:0]        rd_r, wr_r;
    logic [cnt_w-1:0]       cnt_r;
    logic [cmd_width_p-1:0] mem_r [fifo_els_p];

    logic                   empty, full, grant_en, grant_v, deq;
    logic [rr_w-1:0]        grant_idx;
    logic [cmd_width_p-1:0] grant_cmd;

    function automatic logic [fp_w-1:0] fifo_inc(input logic [fp_w-1:0] p);
        return (p == fp_w'(fifo_els_p - 1)) ? '0 : p + 1'b1;
    endfunction

    // Requesters 1..num_req_p-1 form the rotating ring; requester 0 sits outside it.
    function automatic logic [rr_w-1:0] rr_idx(input logic [rr_w-1:0] base, input int off);
        return rr_w'(((int'(base) - 1 + off) % (num_req_p - 1)) + 1);
    endfunction

    assign empty    = (cnt_r == '0);
    assign full     = (cnt_r == cnt_w'(fifo_els_p));
    // A full FIFO blocks even with a same-cycle dequeue, keeping ready off the grant path.
    assign grant_en = !reset_i && (state_r == e_run) && !full && !freeze_i && !flush_i;
    assign deq      = fe_cmd_v_o && fe_cmd_ready_i;

    always_comb begin
        req_yumi_o = '0;
        grant_v    = 1'b0;
        grant_idx  = '0;
        if (grant_en) begin
            if (req_v_i[0]) begin
                grant_v = 1'b1;
            end else begin
                for (int j = 0; j < num_req_p - 1; j++) begin
                    if (!grant_v && req_v_i[rr_idx(rr_r, j)]) begin
                        grant_v   = 1'b1;
                        grant_idx = rr_idx(rr_r, j);
                    end
                end
            end
            if (grant_v)
                req_yumi_o[grant_idx] = 1'b1;
        end
    end

    assign grant_cmd = req_cmd_i[int'(grant_idx)*cmd_width_p +: cmd_width_p];

    always_comb begin
        state_n = state_r;
        if (flush_i) begin
            state_n = e_run;
        end else begin
            case (state_r)
                e_run:   if (|(req_yumi_o & serial_mask_p)) state_n = e_drain;
                e_drain: if (empty) state_n = e_run;
                default: state_n = e_run;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r <= e_run;
            rr_r    <= rr_w'(1);
            rd_r    <= '0;
            wr_r    <= '0;
            cnt_r   <= '0;
        end else begin
            state_r <= state_n;
            if (flush_i) begin
                rd_r  <= '0;
                wr_r  <= '0;
                cnt_r <= '0;
            end else begin
                if (grant_v) wr_r <= fifo_inc(wr_r);
                if (deq)     rd_r <= fifo_inc(rd_r);
                cnt_r <= cnt_r + cnt_w'(grant_v) - cnt_w'(deq);
            end
            if (grant_v && grant_idx != '0)
                rr_r <= (grant_idx == rr_w'(num_req_p - 1)) ? rr_w'(1) : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (grant_v)
            mem_r[wr_r] <= grant_cmd;
    end

    assign fe_cmd_v_o = !empty;
    assign fe_cmd_o   = empty ? '0 : mem_r[rd_r];
    assign busy_o     = !empty || (state_r != e_run);

`ifdef BP_BE_FE_CMD_ARB_STATS_EN
    logic [num_req_p-1:0][15:0] stat_r;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            stat_r <= '0;
        end else if (flush_i) begin
            stat_r <= '0;
        end else begin
            for (int i = 0; i < num_req_p; i++)
                if (req_yumi_o[i] && stat_r[i] != 16'hFFFF)
                    stat_r[i] <= stat_r[i] + 16'd1;
        end
    end

    assign grant_cnt_o = stat_r;
`else
    assign grant_cnt_o = '0;
`endif

endmodule

// File: doc/bp_be_fe_cmd_arbiter.md
Name: bp_be_fe_cmd_arbiter

Overview:
Shares the single BE-to-FE command channel between the checker's redirect sources: trap/ret redirect, mispredict redirect, iTLB fill and TLB fence. It sits between the director-side command generators and the FE cmd interface. It grants at most one requester per cycle into a small output FIFO and presents that FIFO on fe_cmd_o with valid/ready. Serializing commands (fences) are enforced by draining the FIFO before any later grant.

Parameters:
num_req_p, 4, number of requesters; index 0 is highest fixed priority (trap/ret redirect).
cmd_width_p, 64, width of one FE command payload.
fifo_els_p, 2, output FIFO depth; legal values 1..4.
serial_mask_p, 4'b1000, bit i set means requester i issues serializing commands.

Ports:
clk_i  in  1  clock
reset_i  in  1  asynchronous active-high reset
freeze_i  in  1  when high, no grants are made; FIFO output is still drained
flush_i  in  1  discards all FIFO contents next edge
req_v_i  in  num_req_p  per-requester valid
req_cmd_i  in  num_req_p*cmd_width_p  per-requester payload; requester i occupies bits [i*cmd_width_p +: cmd_width_p]
req_yumi_o  out  num_req_p  one-hot grant; consumes the request this cycle
fe_cmd_o  out  cmd_width_p  head-of-FIFO command
fe_cmd_v_o  out  1  FIFO not empty
fe_cmd_ready_i  in  1  FE accepts fe_cmd_o when high with fe_cmd_v_o
busy_o  out  1  FIFO not empty or state != e_run
grant_cnt_o  out  num_req_p*16  per-requester grant counters (see Optional Feature)

Behaviour:
- Reset (async, active-high, clk_i domain):
  - FIFO empty; state e_run; round-robin pointer = 1.
  - Outputs fe_cmd_v_o=0, req_yumi_o=0, busy_o=0, fe_cmd_o=0, grant_cnt_o=0.
- Grant eligibility, evaluated combinationally each cycle: state==e_run, FIFO not full, freeze_i=0, flush_i=0.
  - A full FIFO blocks a grant even if a dequeue happens the same cycle.
- Arbitration:
  - If req_v_i[0], grant requester 0.
  - Otherwise grant round-robin among requesters 1..num_req_p-1, starting at the pointer.
  - After any grant to requester k>=1, the pointer moves to k+1, wrapping from num_req_p-1 to 1. The pointer is unchanged on a grant to 0 or on no grant.
- req_yumi_o is asserted the same cycle as the grant (zero-latency yumi); the payload is written at the edge.
- Latency: a request granted in cycle N is visible on fe_cmd_o with fe_cmd_v_o=1 in cycle N+1 if the FIFO was empty.
- Dequeue happens on fe_cmd_v_o & fe_cmd_ready_i. An enqueue and a dequeue in the same cycle are legal when not full; the count is unchanged.
- FIFO is circular with read and write pointers modulo fifo_els_p, plus a count register 0..fifo_els_p.
- State machine:
  - e_run -> e_drain: on a grant to requester i with serial_mask_p[i]=1.
  - e_drain: no grants. -> e_run on the cycle after the FIFO becomes empty (count==0 at the edge).
  - flush_i in any state: the FIFO is emptied, the state returns to e_run at the next edge, and no grant is made in the flush cycle.
- freeze_i blocks grants only; it does not block dequeue or state transitions.
- Requesters must hold req_v_i and payload stable until yumi. The arbiter makes no combinational path from req_v_i to fe_cmd_v_o.
- Reset asserted mid-operation: all queued commands are lost, nothing is replayed, and no yumi is asserted while reset_i=1.

Optional Feature:
Macro BP_BE_FE_CMD_ARB_STATS_EN.
- Defined: one 16-bit saturating counter per requester, incremented on each req_yumi_o[i]. Counters hold at 16'hFFFF, clear on reset or flush_i, and drive grant_cnt_o.
- Undefined: no counter flops; grant_cnt_o is tied to 0.

Test Plan:
1. Reset released, req_v_i=4'b0010 held, ready=1 -> req_yumi_o=4'b0010 in cycle 0; fe_cmd_o = req 1 payload with fe_cmd_v_o=1 in cycle 1.
2. req_v_i=4'b0111 continuous, ready=1, fifo_els_p=2 -> requester 0 granted every cycle; requesters 1 and 2 never yumi while requester 0 is valid.
3. req_v_i=4'b0110 continuous -> grants alternate 1,2,1,2; the pointer wraps past 3 back to 1.
4. ready=0, req_v_i=4'b0010 for 4 cycles -> exactly 2 yumis, then fe_cmd_v_o=1 with no further yumi. ready=1 for 1 cycle -> one dequeue, one new grant the following cycle.
5. Grant req 3 (serial) while req 1 is valid, ready=0 for 3 cycles -> state e_drain and no yumi to req 1. Once ready=1 drains the FIFO, req 1 is granted the cycle after empty.
6. FIFO holds 2 entries, flush_i=1 for one cycle with req_v_i=4'b0001 -> no yumi that cycle, fe_cmd_v_o=0 next cycle, grant_cnt_o=0 (with macro).
